// File: rtl/twiddle_request_sequencer.sv
// twiddle_request_sequencer: walks an index range, issues paired cos/sin
// lookups to a fixed-latency sine_calculator, re-pairs the responses and
// queues {cos, sin, idx} twiddles for a valid/ready consumer.
// Optional feature macro: TWIDDLE_CONJ_EN (adds conj input; negates tw_sin).
module twiddle_request_sequencer #(
    parameter int unsigned EXP_LEN      = 8,
    parameter int unsigned MANTISSA_LEN = 23,
    parameter int unsigned IDX_W        = 7,
    parameter int unsigned CALC_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IDX_W-1:0]              first_idx,
    input  logic [IDX_W-1:0]              stride,
    input  logic [IDX_W:0]                count,
`ifdef TWIDDLE_CONJ_EN
    input  logic                          conj,
`endif
    output logic                          busy,
    output logic                          calc_enable,
    output logic [EXP_LEN+MANTISSA_LEN:0] calc_theta,
    output logic                          calc_sine_cosine,
    input  logic [EXP_LEN+MANTISSA_LEN:0] calc_value,
    output logic                          tw_valid,
    input  logic                          tw_ready,
    output logic [31:0]                   tw_cos,
    output logic [31:0]                   tw_sin,
    output logic [IDX_W-1:0]              tw_idx
);
    localparam int unsigned DATA_W = EXP_LEN + MANTISSA_LEN + 1;
    localparam int unsigned ROW_W  = IDX_W - 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned CRD_W  = PTR_W + 2;

    typedef enum logic [1:0] {IDLE, ISSUE_COS, ISSUE_SIN, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [IDX_W-1:0]        stride_q, stride_d;
    logic [IDX_W:0]          remaining_q, remaining_d;
    logic                    busy_q, busy_d;
    logic [OCC_W-1:0]        inflight_q, inflight_d;
    logic [CALC_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [CALC_LATENCY-1:0] tag_sin_q, tag_sin_d;
    logic [IDX_W-1:0]        tag_idx_q [CALC_LATENCY];
    logic [IDX_W-1:0]        tag_idx_d [CALC_LATENCY];
    logic [DATA_W-1:0]       cos_hold_q, cos_hold_d;
    logic [DATA_W-1:0]       mem_cos_q [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_cos_d [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_sin_q [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_sin_d [FIFO_DEPTH];
    logic [IDX_W-1:0]        mem_idx_q [FIFO_DEPTH];
    logic [IDX_W-1:0]        mem_idx_d [FIFO_DEPTH];
    logic [OCC_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]        rd_ptr_q, rd_ptr_d;
`ifdef TWIDDLE_CONJ_EN
    logic                    conj_q, conj_d;
`endif

    logic [OCC_W-1:0]  occ;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic              credit_ok;
    logic              cos_issue;
    logic              exit_vld;
    logic              exit_sin;
    logic [IDX_W-1:0]  exit_idx;
    logic [DATA_W-1:0] theta;
    logic [DATA_W-1:0] sin_word;

    // FIFO status and issue credit (queued + pairs still in the calculator)
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
    assign credit_ok  = (CRD_W'(occ) + CRD_W'(inflight_q)) < CRD_W'(FIFO_DEPTH);
    assign fifo_pop   = tw_valid && tw_ready;

    // Angle word for index k: exponent selects table, mantissa top bits select row
    assign theta = {1'b0, EXP_LEN'(k_q[IDX_W-1]), k_q[ROW_W-1:0],
                    {(MANTISSA_LEN-ROW_W){1'b0}}};

    // Sequencer FSM: next state, request strobes and sequence bookkeeping
    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        stride_d         = stride_q;
        remaining_d      = remaining_q;
        calc_enable      = 1'b0;
        calc_sine_cosine = 1'b0;
        calc_theta       = '0;
        cos_issue        = 1'b0;
`ifdef TWIDDLE_CONJ_EN
        conj_d           = conj_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_d     = ISSUE_COS;
                    k_d         = first_idx;
                    stride_d    = (stride == '0) ? IDX_W'(1) : stride;
                    remaining_d = count;
`ifdef TWIDDLE_CONJ_EN
                    conj_d      = conj;
`endif
                end
            end
            ISSUE_COS: begin
                if (credit_ok) begin
                    calc_enable = 1'b1;
                    calc_theta  = theta;
                    cos_issue   = 1'b1;
                    state_d     = ISSUE_SIN;
                end
            end
            ISSUE_SIN: begin
                calc_enable      = 1'b1;
                calc_sine_cosine = 1'b1;
                calc_theta       = theta;
                remaining_d      = remaining_q - (IDX_W+1)'(1);
                k_d              = k_q + stride_q;
                state_d          = (remaining_q == (IDX_W+1)'(1)) ? DRAIN : ISSUE_COS;
            end
            DRAIN: begin
                if ((tag_vld_q == '0) && (inflight_q == '0) && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Tag pipe tracks each request through the calculator latency
    always_comb begin
        tag_vld_d    = '0;
        tag_sin_d    = '0;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = calc_enable;
        tag_sin_d[0] = calc_sine_cosine;
        tag_idx_d[0] = k_q;
        for (int unsigned i = 1; i < CALC_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_sin_d[i] = tag_sin_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    assign exit_vld = tag_vld_q[CALC_LATENCY-1];
    assign exit_sin = tag_sin_q[CALC_LATENCY-1];
    assign exit_idx = tag_idx_q[CALC_LATENCY-1];

`ifdef TWIDDLE_CONJ_EN
    assign sin_word = conj_q ? {~calc_value[DATA_W-1], calc_value[DATA_W-2:0]} : calc_value;
`else
    assign sin_word = calc_value;
`endif

    // Response alignment, in-flight accounting and output FIFO update
    always_comb begin
        cos_hold_d = cos_hold_q;
        mem_cos_d  = mem_cos_q;
        mem_sin_d  = mem_sin_q;
        mem_idx_d  = mem_idx_q;
        fifo_push  = 1'b0;
        if (exit_vld && !exit_sin) begin
            cos_hold_d = calc_value;
        end
        if (exit_vld && exit_sin) begin
            fifo_push = 1'b1;
            mem_cos_d[wr_ptr_q[PTR_W-1:0]] = cos_hold_q;
            mem_sin_d[wr_ptr_q[PTR_W-1:0]] = sin_word;
            mem_idx_d[wr_ptr_q[PTR_W-1:0]] = exit_idx;
        end
        wr_ptr_d   = wr_ptr_q + OCC_W'(fifo_push);
        rd_ptr_d   = rd_ptr_q + OCC_W'(fifo_pop);
        inflight_d = inflight_q + OCC_W'(cos_issue) - OCC_W'(fifo_push);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            inflight_q  <= '0;
            tag_vld_q   <= '0;
            tag_sin_q   <= '0;
            cos_hold_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef TWIDDLE_CONJ_EN
            conj_q      <= 1'b0;
`endif
            for (int unsigned i = 0; i < CALC_LATENCY; i++) begin
                tag_idx_q[i] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_cos_q[i] <= '0;
                mem_sin_q[i] <= '0;
                mem_idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            inflight_q  <= inflight_d;
            tag_vld_q   <= tag_vld_d;
            tag_sin_q   <= tag_sin_d;
            tag_idx_q   <= tag_idx_d;
            cos_hold_q  <= cos_hold_d;
            mem_cos_q   <= mem_cos_d;
            mem_sin_q   <= mem_sin_d;
            mem_idx_q   <= mem_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef TWIDDLE_CONJ_EN
            conj_q      <= conj_d;
`endif
        end
    end

    // Outputs present the FIFO head
    assign busy     = busy_q;
    assign tw_valid = !fifo_empty;
    assign tw_cos   = 32'(mem_cos_q[rd_ptr_q[PTR_W-1:0]]);
    assign tw_sin   = 32'(mem_sin_q[rd_ptr_q[PTR_W-1:0]]);
    assign tw_idx   = mem_idx_q[rd_ptr_q[PTR_W-1:0]];

    // Credit scheme must never let a push land on a full FIFO without a pop
    fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_twiddle_request_sequencer.sv
// Testbench for twiddle_request_sequencer: calculator model with a toy ROM,
// request and twiddle scoreboards, randomized sequences and ready patterns.
module tb_twiddle_request_sequencer;
    localparam int unsigned CALC_LATENCY = 2;
    localparam int unsigned IDX_W        = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  first_idx;
    logic [6:0]  stride;
    logic [7:0]  count;
`ifdef TWIDDLE_CONJ_EN
    logic        conj;
`endif
    logic        busy;
    logic        calc_enable;
    logic [31:0] calc_theta;
    logic        calc_sine_cosine;
    logic [31:0] calc_value;
    logic        tw_valid;
    logic        tw_ready;
    logic [31:0] tw_cos;
    logic [31:0] tw_sin;
    logic [6:0]  tw_idx;

    twiddle_request_sequencer #(
        .EXP_LEN(8), .MANTISSA_LEN(23), .IDX_W(IDX_W),
        .CALC_LATENCY(CALC_LATENCY), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_idx(first_idx), .stride(stride), .count(count),
`ifdef TWIDDLE_CONJ_EN
        .conj(conj),
`endif
        .busy(busy), .calc_enable(calc_enable), .calc_theta(calc_theta),
        .calc_sine_cosine(calc_sine_cosine), .calc_value(calc_value),
        .tw_valid(tw_valid), .tw_ready(tw_ready),
        .tw_cos(tw_cos), .tw_sin(tw_sin), .tw_idx(tw_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_mode = 0;     // 0: always ready, 1: random, 2: never
    int req_pairs = 0;
    int pops = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;

    typedef struct packed {
        logic [31:0] c;
        logic [31:0] s;
        logic [6:0]  idx;
    } tw_t;

    tw_t         exp_tw[$];
    logic [32:0] exp_req[$];   // {sine_cosine, theta}

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Toy calculator ROM: distinct word for every (table, row, sin/cos)
    function automatic logic [31:0] rom(input int e, input int row, input bit s);
        logic [31:0] key;
        key = 32'(e * 128 + row * 2 + int'(s));
        return key * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] theta_of(input int k);
        return ((k >= 64) ? 32'h0080_0000 : 32'h0) | (32'(k % 64) << 17);
    endfunction

    // Calculator model: fixed-latency pipeline answering each sampled request
    logic [33:0] cpipe [CALC_LATENCY];
    logic [33:0] cout;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CALC_LATENCY; i++) cpipe[i] <= '0;
        end else begin
            cpipe[0] <= {calc_enable, calc_sine_cosine, calc_theta};
            for (int i = 1; i < CALC_LATENCY; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign cout = cpipe[CALC_LATENCY-1];
    assign calc_value = cout[33] ? rom(int'(cout[23]), int'(cout[22:17]), cout[32]) : 32'hDEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern driver
    initial begin
        tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tw_ready = 1'b1;
                1: tw_ready = ($urandom_range(0, 99) < 70);
                default: tw_ready = 1'b0;
            endcase
        end
    end

    // Monitor: requests, popped twiddles, and head stability under stall
    logic        stall_prev = 1'b0;
    logic [70:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (calc_enable) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got theta %0h sc %0b with none expected", calc_theta, calc_sine_cosine);
                end else begin
                    chk("request", {calc_sine_cosine, calc_theta}, exp_req.pop_front());
                    if (calc_sine_cosine) req_pairs++;
                end
            end
            if (stall_prev && tw_valid) chk("hold_stable", {tw_cos, tw_sin, tw_idx}, held);
            if (tw_valid && tw_ready) begin
                if (exp_tw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tw_unexpected: got idx %0d with none expected", tw_idx);
                end else begin
                    chk("twiddle", {tw_cos, tw_sin, tw_idx}, exp_tw.pop_front());
                end
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            stall_prev = tw_valid && !tw_ready;
            held = {tw_cos, tw_sin, tw_idx};
        end
    end

    // Reference model: expected requests and twiddles for one sequence
    task automatic push_seq(input int f, input int st, input int cn, input bit cj);
        int k;
        int s;
        tw_t t;
        k = f;
        s = (st == 0) ? 1 : st;
        for (int i = 0; i < cn; i++) begin
            exp_req.push_back({1'b0, theta_of(k)});
            exp_req.push_back({1'b1, theta_of(k)});
            t.c = rom(k / 64, k % 64, 1'b0);
            t.s = rom(k / 64, k % 64, 1'b1);
            if (cj) t.s[31] = ~t.s[31];
            t.idx = 7'(k);
            exp_tw.push_back(t);
            k = (k + s) % 128;
        end
    endtask

    task automatic pulse_start(input int f, input int st, input int cn, input bit cj);
        @(posedge clk); #1;
        first_idx = 7'(f);
        stride    = 7'(st);
        count     = 8'(cn);
`ifdef TWIDDLE_CONJ_EN
        conj      = cj;
`else
        if (cj) $display("conj ignored in this build");
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {busy, calc_enable, calc_sine_cosine, tw_valid}, 4'b0);
        chk({tag, "_theta"}, calc_theta, 32'h0);
        chk({tag, "_tw"}, {tw_cos, tw_sin, tw_idx}, 71'h0);
    endtask

    // One full sequence: latency, drain, count and throughput checks
    task automatic run_seq(input int f, input int st, input int cn, input bit cj, input bit glitch);
        int  n;
        bit  seen;
        push_seq(f, st, cn, cj);
        pops = 0; req_pairs = 0; first_pop_cyc = -1; last_pop_cyc = -1;
        pulse_start(f, st, cn, cj);
        if (cn == 0) begin
            for (int i = 0; i < 4; i++) begin
                chk("count0_idle", {busy, calc_enable, tw_valid}, 3'b0);
                @(posedge clk); #1;
            end
            return;
        end
        chk("busy_rise", busy, 1'b1);
        n = 0; seen = 1'b0;
        while (busy && n < 3000) begin
            if (!seen && tw_valid) begin
                seen = 1'b1;
                chk("first_latency", n, CALC_LATENCY + 2);
            end
            if (glitch && n == 3) begin
                first_idx = 7'(f + 33); count = 8'(cn + 5); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL seq_timeout: busy still %0b after %0d cycles", busy, n);
        end
        @(negedge clk);
        chk("drained_tw", exp_tw.size(), 0);
        chk("drained_req", exp_req.size(), 0);
        chk("pop_count", pops, cn);
        if (ready_mode == 0 && cn > 1) chk("throughput", last_pop_cyc - first_pop_cyc, 2 * (cn - 1));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy still %0b", tag, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; first_idx = '0; stride = '0; count = '0;
`ifdef TWIDDLE_CONJ_EN
        conj = 1'b0;
`endif
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single twiddle, idx 5
        run_seq(5, 1, 1, 1'b0, 1'b0);
        // Table crossing 62..65
        run_seq(62, 1, 4, 1'b0, 1'b0);
        // Wrap-around
        run_seq(120, 4, 4, 1'b0, 1'b0);
        // Stride 0 behaves as 1; start while busy is ignored
        run_seq(30, 0, 3, 1'b0, 1'b1);
        // Count 0 ignored
        run_seq(7, 1, 0, 1'b0, 1'b0);
        // Longest sequence with a large stride
        run_seq(3, 77, 20, 1'b0, 1'b0);

        // Backpressure: credit stops issue once four pairs are queued
        ready_mode = 2;
        push_seq(9, 3, 10, 1'b0);
        pops = 0; req_pairs = 0;
        pulse_start(9, 3, 10, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        chk("bp_pairs_issued", req_pairs, 4);
        chk("bp_no_issue", calc_enable, 1'b0);
        chk("bp_valid_busy", {tw_valid, busy}, 2'b11);
        ready_mode = 0;
        wait_idle("bp");
        @(negedge clk);
        chk("bp_pop_count", pops, 10);
        chk("bp_drained", exp_tw.size(), 0);
        @(posedge clk); #1;

        // Reset mid-sequence discards everything
        push_seq(40, 2, 6, 1'b0);
        pulse_start(40, 2, 6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_tw.delete();
        exp_req.delete();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check_reset_outputs("midrst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_seq(17, 5, 5, 1'b0, 1'b0);

`ifdef TWIDDLE_CONJ_EN
        run_seq(16, 1, 1, 1'b1, 1'b0);
`endif

        // Randomized sequences and ready patterns
        for (int i = 0; i < 12; i++) begin
            int f, st, cn;
            ready_mode = int'($urandom_range(0, 1));
            f  = int'($urandom_range(0, 127));
            st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 127));
            cn = int'($urandom_range(1, 12));
            run_seq(f, st, cn, 1'b0, $urandom_range(0, 1) == 1);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/twiddle_request_sequencer.md
Name: twiddle_request_sequencer

Overview:
- Initiator and consumer for the LUT-based sine_calculator. It walks an index range and issues paired cosine/sine lookups.
- It aligns the fixed-latency responses and delivers {cos, sin, index} twiddle words to a downstream NTT/FFT butterfly over a valid/ready interface.
- A small output FIFO decouples calculator latency from downstream backpressure. Credit-based issue prevents overflow.

Parameters:
- EXP_LEN, 8, float exponent width (matches sine_calculator)
- MANTISSA_LEN, 23, float mantissa width
- IDX_W, 7, index width; bit 6 selects the exponent table, bits 5:0 select the LUT row
- CALC_LATENCY, 2, cycles from calc_enable sample to calc_value valid
- FIFO_DEPTH, 4, output FIFO entries (power of two, at least 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches a sequence when idle
- first_idx  in  IDX_W  first index of the sequence
- stride  in  IDX_W  index increment, 0 is illegal (treated as 1)
- count  in  IDX_W+1  number of twiddles, 0 = none
- busy  out  1  high from start accept until the last twiddle is popped
- calc_enable  out  1  request strobe to sine_calculator
- calc_theta  out  EXP_LEN+MANTISSA_LEN+1  angle word
- calc_sine_cosine  out  1  1 = sine, 0 = cosine
- calc_value  in  EXP_LEN+MANTISSA_LEN+1  calculator result
- tw_valid  out  1  twiddle available
- tw_ready  in  1  downstream accept
- tw_cos  out  32  cosine word
- tw_sin  out  32  sine word
- tw_idx  out  IDX_W  index of this twiddle

Behaviour:
- Clock and reset: clk, rst_n. Reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; in-flight tag pipe cleared.
- Angle encoding for index k:
  - sign = 0
  - exponent = zero-extended k[6]
  - mantissa = {k[5:0], 17'b0}
- FSM states:
  - IDLE: start with count != 0 captures first_idx/stride/count and goes to ISSUE_COS. With count = 0, start is ignored and busy stays 0. start outside IDLE is ignored.
  - ISSUE_COS: if credit is available, drive calc_enable = 1, sine_cosine = 0, theta(k), then go to ISSUE_SIN. If no credit, hold with calc_enable = 0.
  - ISSUE_SIN: calc_enable = 1, sine_cosine = 1, same theta. Decrement remaining and set k <= k + stride (wraps modulo 2^IDX_W). If remaining becomes 0, go to DRAIN; otherwise go to ISSUE_COS.
  - DRAIN: wait until the tag pipe is empty and the FIFO is empty, then go to IDLE and drop busy.
- Credit: a COS issue is allowed only if FIFO occupancy + pairs in flight < FIFO_DEPTH.
- Tag pipe:
  - CALC_LATENCY-deep shift register of {valid, is_sin, idx} in parallel with each request.
  - At tag exit with is_sin = 0: calc_value goes to the cos holding register.
  - At tag exit with is_sin = 1: {cos_hold, calc_value, idx} is pushed into the FIFO.
- The pipe never stalls; the credit rule guarantees the push never meets a full FIFO. A push to a full FIFO is a design error; flag it with an assertion.
- Output handshake:
  - tw_* reflect the FIFO head; tw_valid = not empty.
  - A pop occurs when tw_valid && tw_ready.
  - Simultaneous push and pop is legal at any occupancy, including full-with-pop.
- Throughput: one twiddle per 2 cycles when unthrottled. First tw_valid appears CALC_LATENCY+2 cycles after start.
- Data outputs hold stable while tw_valid && !tw_ready.
- Reset asserted mid-sequence: immediate return to reset values; in-flight results are discarded.

Optional Feature:
- Macro TWIDDLE_CONJ_EN.
- Defined: adds input port conj (1 bit), sampled at start accept. When set, tw_sin is pushed with its sign bit inverted (conjugate twiddle for inverse transforms). tw_cos is unchanged.
- Undefined: no conj port; tw_sin is exactly calc_value.

Test Plan:
- Single twiddle, first_idx = 5, count = 1, tw_ready = 1:
  - two requests: theta = 0x000A0000 with sine_cosine = 0, then the same theta with sine_cosine = 1
  - tw_valid for one cycle with tw_idx = 5 and values equal to the model ROM rows for exp 0, row 5
  - busy falls after the pop
- Table crossing, first_idx = 62, stride = 1, count = 4:
  - tw_idx sequence 62, 63, 64, 65
  - the 64 request has exponent field 1 and mantissa 0
- Wrap-around, first_idx = 120, stride = 4, count = 4: tw_idx sequence 120, 124, 0, 4.
- Backpressure, count = 10, tw_ready = 0 for 20 cycles:
  - FIFO fills to 4
  - calc_enable stays 0 once credit is exhausted
  - no overflow assertion fires
  - after release, all 10 twiddles arrive in order with none dropped
- Reset mid-sequence, rst_n low on cycle 3 after start: all outputs 0 during reset; a fresh start afterwards produces a clean sequence.
- With TWIDDLE_CONJ_EN and conj = 1, idx 16: tw_sin sign bit is the inverse of the ROM value; tw_cos is unchanged.
